// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM states, default latencies.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing the {hi,lo} result for the current operands.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] divisor;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
  assign signed_div = (op == MDU_DIV);
  assign dvd_mag    = (signed_div && a[31]) ? (32'd0 - a) : a;
  assign dvs_mag    = (signed_div && b[31]) ? (32'd0 - b) : b;
  assign divisor    = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign q_u        = dvd_mag / divisor;
  assign r_u        = dvd_mag % divisor;
  assign quot       = (signed_div && (a[31] ^ b[31])) ? (32'd0 - q_u) : q_u;
  assign rem        = (signed_div && a[31]) ? (32'd0 - r_u) : r_u;

  always_comb begin
    result = 64'd0;
    case (op)
      MDU_MULT:           result = prod_s;
      MDU_MULTU:          result = prod_u;
      MDU_DIV, MDU_DIVU:  result = {rem, quot};
      default:            result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and fixed-latency mult/div sequencer; result is computed at start and committed after the busy window.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      sh_hi_reg, sh_hi_next;
  logic [31:0]      sh_lo_reg, sh_lo_next;
  logic [63:0]      arith_result;
  mdu_state_e       state;

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (arith_result)
  );

  assign state = (cnt_reg != '0) ? ST_RUN : ST_IDLE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg   <= '0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      sh_hi_reg <= 32'd0;
      sh_lo_reg <= 32'd0;
    end else begin
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      sh_hi_reg <= sh_hi_next;
      sh_lo_reg <= sh_lo_next;
    end
  end

  always_comb begin
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    sh_hi_next = sh_hi_reg;
    sh_lo_next = sh_lo_reg;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              {sh_hi_next, sh_lo_next} = arith_result;
              cnt_next = CNT_W'(MULT_CYCLES);
            end
            MDU_DIV, MDU_DIVU: begin
              // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged.
              {sh_hi_next, sh_lo_next} = (b == 32'd0) ? {hi_reg, lo_reg} : arith_result;
              cnt_next = CNT_W'(DIV_CYCLES);
            end
            MDU_MTHI: hi_next = a;
            MDU_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          hi_next = sh_hi_reg;
          lo_next = sh_lo_reg;
        end
      end
      default: cnt_next = '0;
    endcase
  end

  assign busy      = (state == ST_RUN);
  assign stall_req = busy | (start & is_muldiv(op));
  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign rdata     = (op == MDU_MFHI) ? hi_reg : (op == MDU_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed, table-driven bench for mdu_ctrl plus hand sequences for busy-time mthi and reset abort.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = MDU_MULT;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic exp_stall);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    #1;
    chk("stall_req_at_start", {31'd0, stall_req}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    start = 1'b0; op = MDU_MULT;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      chk("stall_req_while_busy", {31'd0, stall_req}, 32'd1);
      n++;
      @(posedge clk);
      #1;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_regs(input string tag, input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    @(negedge clk);
    op = MDU_MFHI; #1;
    chk({tag, "_rdata_mfhi"}, rdata, eh);
    op = MDU_MFLO; #1;
    chk({tag, "_rdata_mflo"}, rdata, el);
    op = MDU_MULT; #1;
    chk({tag, "_rdata_other"}, rdata, 32'd0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{"mult_m2x3",      MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{"multu_ffx2",     MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{"div_m7d2",       MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"divu_7d2",       MDU_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{"div_min_dm1",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{"div_5d0",        MDU_DIV,   32'd5,        32'd0,        32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{"mult_7xm3",      MDU_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[7]  = '{"divu_ffd16",     MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8]  = '{"div_7dm2",       MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{"multu_2p16sq",   MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[10] = '{"mthi",           MDU_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h00000000, 0};
    vecs[11] = '{"mtlo",           MDU_MTLO,  32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0};

    // Reset state while reset is held low.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    $display("reset: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, is_muldiv(vecs[i].op));
      wait_idle(n);
      chk({vecs[i].name, "_busy_cycles"}, n, vecs[i].cycles);
      check_regs(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
      $display("%s: a=0x%08h b=0x%08h busy=%0d hi=0x%08h lo=0x%08h", vecs[i].name,
               vecs[i].a, vecs[i].b, n, hi, lo);
    end

    // mthi arriving while a mult is running must be dropped.
    issue(MDU_MULT, 32'd2, 32'd3, 1'b1);
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; a = 32'hDEADBEEF;
    #1;
    chk("mthi_busy_stall", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; op = MDU_MULT;
    wait_idle(n);
    check_regs("mthi_while_busy", 32'd0, 32'd6);
    $display("mthi_while_busy: hi=0x%08h lo=0x%08h", hi, lo);

    // Reset asserted during busy cycle 3 of a mult aborts it with no later commit.
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_commit_hi", hi, 32'd0);
    chk("abort_no_commit_lo", lo, 32'd0);
    $display("reset_mid_run: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
